// File: rtl/seq_detect_mealy_p.sv
// Parametrised Mealy sequence detector with a run-time-loadable pattern.
// The matched-prefix fallback (KMP-style) is derived combinationally from the
// pattern register every cycle, so a newly loaded pattern takes effect at once.
// outp is same-cycle; outp_q and the saturating match_cnt are registered.
module seq_detect_mealy_p #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inp,
  input  logic                       inp_valid,
  input  logic                       pat_load,
  input  logic [PAT_W-1:0]           pat_in,
  input  logic                       cnt_clr,
  output logic                       outp,
  output logic                       outp_q,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [$clog2(PAT_W)-1:0]   state_o
);

  localparam int SW = $clog2(PAT_W);
  localparam logic [SW-1:0]    LAST_ST = SW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // State k = number of leading pattern bits currently matched (0..PAT_W-1).
  typedef logic [SW-1:0] state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               outp_q_r;
  state_t             fb_state;

  // Registers: state, pattern, registered match flag and match counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= '0;
      pat_q    <= PATTERN;
      cnt_q    <= '0;
      outp_q_r <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      cnt_q    <= cnt_d;
      outp_q_r <= outp;
    end
  end

  // Fallback: longest j <= k+1 (capped at PAT_W-1) such that the last j bits of
  // (prefix_k, inp) equal the first j pattern bits. The prefix bits are pattern
  // bits themselves, so only inp and the pattern register are compared.
  // With k = PAT_W-1 and a matching bit this yields the longest proper border.
  always_comb begin
    int  k;
    logic ok;
    fb_state = '0;
    k        = int'(state_q);
    ok       = 1'b0;
    for (int j = 1; j < PAT_W; j++) begin
      ok = (j <= k + 1) && (inp == pat_q[PAT_W-j]);
      for (int m = 0; m < PAT_W - 1; m++) begin
        if (ok && (m < j - 1)) begin
          if (pat_q[PAT_W-2-k+j-m] != pat_q[PAT_W-1-m]) ok = 1'b0;
        end
      end
      if (ok) fb_state = SW'(j);
    end
  end

  // Next-state, pattern load, Mealy output and counter update.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    outp    = inp_valid & ~pat_load & (state_q == LAST_ST) & (inp == pat_q[0]);

    if (pat_load) begin
      pat_d   = pat_in;
      state_d = '0;
    end else if (inp_valid) begin
      if (outp && !OVERLAP) state_d = '0;
      else                  state_d = fb_state;
    end

    if (cnt_clr)                        cnt_d = '0;
    else if (outp && cnt_q != CNT_MAX)  cnt_d = cnt_q + 1'b1;
  end

  assign outp_q    = outp_q_r;
  assign match_cnt = cnt_q;
  assign state_o   = state_q;

endmodule

// File: doc/seq_detect_mealy_p.md
Name: seq_detect_mealy_p

Overview:
- Parametrised Mealy sequence detector; next generation of the team's single-pattern serial detector.
- Watches a qualified serial bit stream for a PAT_W-bit pattern, held in a run-time-loadable register.
- Asserts a same-cycle Mealy match output, plus a registered copy.
- Supports overlapping or non-overlapping detection and counts matches in a saturating counter.
- Sits behind a serial front end; feeds status/interrupt logic.

Parameters:
- PAT_W, 4: pattern length in bits. Legal range 2..16.
- PATTERN, 4'b1011: reset value of the pattern register. Bit PAT_W-1 is the first bit expected on the stream.
- OVERLAP, 1: 1 means the tail of a match may start the next match; 0 means detection restarts from empty after a match.
- CNT_W, 8: match counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- inp  in  1  serial data bit
- inp_valid  in  1  inp is sampled only when high
- pat_load  in  1  load pat_in into the pattern register
- pat_in  in  PAT_W  new pattern
- cnt_clr  in  1  synchronous clear of match_cnt
- outp  out  1  Mealy match, combinational
- outp_q  out  1  outp registered one cycle
- match_cnt  out  CNT_W  saturating match count
- state_o  out  clog2(PAT_W)  current matched-prefix length, for debug

Behaviour:
- Reset: rst is asynchronous and active-high; only clk is used. On rst:
  - state = 0
  - pattern register = PATTERN
  - outp_q = 0, match_cnt = 0
  - outp = 0, because state 0 cannot complete a match when PAT_W ≥ 2.
- Reset mid-operation discards any partial match immediately.
- State meaning: state k (0..PAT_W-1) means the last k accepted bits equal pattern bits [PAT_W-1 : PAT_W-k]. State PAT_W is never stored.
- Mealy output: outp = inp_valid & ~pat_load & (state == PAT_W-1) & (inp == pattern[0]). It is purely combinational from state, pattern and inputs, with zero latency.
- Transition on a clock edge with inp_valid=1 and pat_load=0, for accepted bit b:
  - Form string S = matched prefix of length k followed by b.
  - Normal case: next state = largest j ≤ min(k+1, PAT_W-1) such that the last j bits of S equal the first j pattern bits. This is a KMP-style fallback, not a reset to 0.
  - On a match (outp=1), OVERLAP=1: next state = length of the longest proper border of the full pattern.
  - On a match (outp=1), OVERLAP=0: next state = 0.
  - Fallback is computed combinationally from the pattern register each cycle; a lookup table is not permitted, because the pattern is run-time loadable.
- inp_valid=0: state holds, outp=0, and inp is ignored.
- pat_load=1:
  - The pattern register takes pat_in and state goes to 0 at the edge.
  - outp is forced to 0 that cycle.
  - inp is ignored that cycle even if inp_valid=1.
  - match_cnt is unaffected.
- outp_q: registers outp every edge.
- match_cnt:
  - +1 on each edge where outp=1.
  - Saturates at 2^CNT_W-1 with no wrap.
  - cnt_clr=1 sets it to 0. If cnt_clr and outp coincide, the result is 0 (clear wins, and that match is not counted).
- Pattern semantics: all-zero and all-one patterns are legal. For all-ones with OVERLAP=1, a run of N ones yields N-PAT_W+1 matches.

Test Plan:
1. PATTERN=1011, OVERLAP=1, stream 1,0,1,1,0,1,1 (valid every cycle) -> outp high on bits 4 and 7 only; outp_q high one cycle later each time; match_cnt=2.
2. Same stream with OVERLAP=0 -> outp high on bit 4 only; match_cnt=1; state_o after bit 7 = 1.
3. Stream 1,0,1,1 with inp_valid low for 3 cycles between bits 2 and 3 -> state_o holds at 2 during the gap; outp=0 during the gap; outp high on bit 4.
4. pat_load with pat_in=1111, OVERLAP=1, then six 1s -> matches on bits 4, 5 and 6; match_cnt increments by 3. A pat_load asserted together with a valid bit -> that bit is ignored and state_o=0.
5. CNT_W=3, 9 matches -> match_cnt stops at 7. cnt_clr asserted on the same cycle as a match -> match_cnt=0.
6. After bits 1,0,1 (state_o=3), assert rst asynchronously between edges -> state_o, outp_q and match_cnt go to 0 immediately. After release, a fresh 1,0,1,1 gives exactly one match.
